bin_msg_packer: RTL and testbench
=================================

# bin_msg_packer

Downstream stage of the codeword decoder top level. It collects the serial decoded message bits (`bin_msg`, one bit per valid strobe) into OUT_W-bit words and marks the final, possibly partial, word of each message. It presents the words on a valid/ready interface to the host-side consumer through a 2-entry output queue. The decoder has no backpressure, so queue overflow drops the word and raises a sticky error.

## Interface
- `OUT_W`, 8, output word width in bits (≥2)
- `NB_W`, `$clog2(OUT_W+1)`, width of the valid-bit count

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `bin_msg`  in  1  decoded message bit
- `bin_vld`  in  1  `bin_msg` valid this cycle
- `msg_done`  in  1  single-cycle strobe marking end of message
- `out_data`  out  OUT_W  packed word; first-received bit at MSB; partial words left-aligned, zero-padded
- `out_nbits`  out  NB_W  number of valid bits in `out_data` (OUT_W for full words)
- `out_last`  out  1  word is the final word of its message
- `out_valid`  out  1  queue head is valid
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`
- `busy`  out  1  `bit_cnt != 0` or queue non-empty
- `ovf`  out  1  sticky overflow error; cleared only by reset

## Operation
- Assembly register `acc[OUT_W-1:0]` and counter `bit_cnt` (0..OUT_W-1).
- On `bin_vld`, the bit goes to `acc[OUT_W-1-bit_cnt]` and `bit_cnt` increments.
- When `bin_vld` arrives with `bit_cnt == OUT_W-1`, push {acc with bit, nbits=OUT_W, last=msg_done}, then `bit_cnt` resets to 0 and `acc` clears.
- On `msg_done`, the bit presented with `bin_vld` in the same cycle belongs to the ending message.
  - If the resulting word is full, it is pushed with last=1, as above.
  - If the resulting count is 1..OUT_W-1, push {acc, nbits=count, last=1}.
  - If the resulting count is 0 (no bits since the last push), push {0, nbits=0, last=1}.
  - `bit_cnt` and `acc` then clear; subsequent bits start a new message.
- At most one push per cycle.
- Queue: 2 entries, FIFO order, each entry {data, nbits, last}.
  - Pop occurs when `out_valid & out_ready`.
  - A push when full with a simultaneous pop is accepted.
  - A push when full without a pop is dropped: the queue is unchanged, `ovf` is set, and assembly state still clears as if the word had been pushed.
- `out_*` are driven from the queue head. `out_data`, `out_nbits` and `out_last` are held stable while `out_valid & ~out_ready`.
- Reset (any time, including mid-message) clears `acc`, `bit_cnt`, the queue and `ovf`. A partial word in flight is discarded.

## Timing
- Reset values: `out_data`=0, `out_nbits`=0, `out_last`=0, `out_valid`=0, `busy`=0, `ovf`=0.
- Latency: a push in cycle N (with the queue empty) gives `out_valid`=1 in cycle N+1.
- Back-to-back pops sustain 1 word/cycle. Pop of the head in cycle N exposes the second entry in cycle N+1.
- `ovf` rises in the cycle after the dropped push.
- `busy` is registered and reflects state after the current edge.
- `out_valid` never deasserts without a pop, except on reset.

## Test plan
- OUT_W=8, bits 1,0,1,1,0,0,1,0 on consecutive cycles, then `msg_done` with no bit, `out_ready`=1 -> words 0xB2 (nbits 8, last 0), then 0x00 (nbits 0, last 1); first `out_valid` one cycle after the 8th bit.
- 3 bits 1,1,0, with `msg_done` asserted together with the 3rd bit -> one word 0xC0, nbits 3, last 1; `busy` falls after the pop.
- 8 bits 0xA5 with `msg_done` on the 8th bit -> single word 0xA5, nbits 8, last 1; no extra empty word.
- `out_ready`=0, 24 continuous bits -> first two words queued, third dropped; `ovf`=1 and stays 1. After raising `out_ready`, exactly 2 words drain intact and `out_valid` drops.
- Queue full, `out_ready`=1 in the same cycle as a third push -> no `ovf`; all three words emerge in order.
- `rst` asserted after 5 bits of a message -> all outputs at reset values immediately. A new message of 8 bits 0xFF then yields 0xFF, nbits 8, with no residue from the aborted bits.

Source files
------------

// File: rtl/bin_msg_packer_if.sv
// Bit-in / word-out bus of the message packer.
// master: the packer (takes decoder bits, presents words).
// slave:  the surrounding logic (decoder source, host-side consumer).
interface bin_msg_packer_if #(
   parameter int OUT_W = 8,
   parameter int NB_W  = $clog2(OUT_W + 1)
);
   logic             bin_msg;
   logic             bin_vld;
   logic             msg_done;
   logic [OUT_W-1:0] out_data;
   logic [NB_W-1:0]  out_nbits;
   logic             out_last;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             ovf;

   modport master (
      input  bin_msg, bin_vld, msg_done, out_ready,
      output out_data, out_nbits, out_last, out_valid, busy, ovf
   );

   modport slave (
      output bin_msg, bin_vld, msg_done, out_ready,
      input  out_data, out_nbits, out_last, out_valid, busy, ovf
   );
endinterface

// File: rtl/bin_msg_packer.sv
// Packs serial decoded message bits MSB-first into OUT_W-bit words; last word of a message may be partial.
// Latency: word pushed in cycle N is visible at the output in cycle N+1 (queue empty).
// Backpressure: 2-entry output queue; the decoder cannot stall, so a push into a full queue is dropped and ovf sticks.
module bin_msg_packer #(
   parameter int OUT_W = 8,
   parameter int NB_W  = $clog2(OUT_W + 1)
) (
   input  logic                clk,
   input  logic                rst,
   bin_msg_packer_if.master    pk
);

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic [NB_W-1:0]  nbits;
      logic             last;
   } entry_t;

   localparam logic [NB_W-1:0] LAST_IDX = NB_W'(OUT_W - 1);

   logic [OUT_W-1:0] acc_q, acc_d, acc_new;
   logic [NB_W-1:0]  cnt_q, cnt_d, cnt_new;
   entry_t           head_q, head_d, tail_q, tail_d, push_ent;
   logic [1:0]       qcnt_q, qcnt_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             push, pop;

   // Assembly: drop the incoming bit into its MSB-first slot and decide whether a word leaves this cycle.
   always_comb begin
      acc_new = acc_q;
      cnt_new = cnt_q;
      if (pk.bin_vld) begin
         for (int i = 0; i < OUT_W; i++) begin
            if (cnt_q == NB_W'(OUT_W - 1 - i)) acc_new[i] = pk.bin_msg;
         end
         cnt_new = cnt_q + NB_W'(1);
      end
      // A word leaves when it fills up or the message ends (possibly with zero bits).
      push           = (pk.bin_vld && (cnt_q == LAST_IDX)) || pk.msg_done;
      push_ent.data  = acc_new;
      push_ent.nbits = cnt_new;
      push_ent.last  = pk.msg_done;
      // Assembly clears on every push attempt, even if the queue drops the word.
      acc_d = push ? '0 : acc_new;
      cnt_d = push ? '0 : cnt_new;
   end

   // Output queue: head/tail pair; pop frees a slot before the same-cycle push is considered.
   always_comb begin
      pop    = (qcnt_q != 2'd0) && pk.out_ready;
      head_d = head_q;
      tail_d = tail_q;
      qcnt_d = qcnt_q;
      ovf_d  = ovf_q;
      case ({push, pop})
         2'b01: begin
            head_d = tail_q;
            tail_d = '0;
            qcnt_d = qcnt_q - 2'd1;
         end
         2'b11: begin
            if (qcnt_q == 2'd1) begin
               head_d = push_ent;
            end else begin
               head_d = tail_q;
               tail_d = push_ent;
            end
         end
         2'b10: begin
            if (qcnt_q == 2'd0) begin
               head_d = push_ent;
               qcnt_d = 2'd1;
            end else if (qcnt_q == 2'd1) begin
               tail_d = push_ent;
               qcnt_d = 2'd2;
            end else begin
               ovf_d = 1'b1;
            end
         end
         default: ;
      endcase
      busy_d = (cnt_d != '0) || (qcnt_d != 2'd0);
   end

   // State registers; reset discards any partial word and all queued words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         qcnt_q <= 2'd0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         qcnt_q <= qcnt_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
      end
   end

   assign pk.out_data  = head_q.data;
   assign pk.out_nbits = head_q.nbits;
   assign pk.out_last  = head_q.last;
   assign pk.out_valid = (qcnt_q != 2'd0);
   assign pk.busy      = busy_q;
   assign pk.ovf       = ovf_q;

endmodule

// File: tb/tb_bin_msg_packer.sv
// Randomized + directed bench for bin_msg_packer with a queue-based reference model and scoreboard.
module tb_bin_msg_packer;
   localparam int OUT_W = 8;
   localparam int NB_W  = $clog2(OUT_W + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bin_msg_packer_if #(.OUT_W(OUT_W), .NB_W(NB_W)) pk ();
   bin_msg_packer #(.OUT_W(OUT_W), .NB_W(NB_W)) dut (.clk(clk), .rst(rst), .pk(pk));

   typedef struct {
      int data;
      int nbits;
      int last;
   } word_t;

   int    checks = 0;
   int    errors = 0;
   word_t sb[$];      // expected words accepted into the queue, in order
   bit    bits_q[$];  // bits of the word currently being assembled
   int    occ = 0;    // reference queue occupancy
   bit    ovf_exp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: message bits gathered in a list, words formed from the list, queue tracked as a count.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sb.delete();
         bits_q.delete();
         occ = 0;
         ovf_exp = 1'b0;
      end else begin
         if (occ > 0 && pk.out_ready) occ--;
         if (pk.bin_vld) bits_q.push_back(pk.bin_msg);
         if (bits_q.size() == OUT_W || pk.msg_done) begin
            word_t w;
            w.data = 0;
            for (int i = 0; i < bits_q.size(); i++)
               if (bits_q[i]) w.data |= (1 << (OUT_W - 1 - i));
            w.nbits = bits_q.size();
            w.last  = pk.msg_done;
            bits_q.delete();
            if (occ < 2) begin
               occ++;
               sb.push_back(w);
            end else begin
               ovf_exp = 1'b1;
            end
         end
      end
   end

   // Monitor: every cycle check flags; on each accepted word compare against the scoreboard head.
   always @(negedge clk) begin
      word_t w;
      if (rst) begin
         chk("rst_valid", pk.out_valid, 0);
         chk("rst_data",  pk.out_data, 0);
         chk("rst_nbits", pk.out_nbits, 0);
         chk("rst_last",  pk.out_last, 0);
         chk("rst_busy",  pk.busy, 0);
         chk("rst_ovf",   pk.ovf, 0);
      end else begin
         chk("valid", pk.out_valid, occ > 0);
         chk("ovf",   pk.ovf, ovf_exp);
         chk("busy",  pk.busy, (bits_q.size() != 0) || (occ != 0));
         if (pk.out_valid && pk.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got word %0h expected none", pk.out_data);
            end else begin
               w = sb.pop_front();
               chk("data",  pk.out_data, w.data);
               chk("nbits", pk.out_nbits, w.nbits);
               chk("last",  pk.out_last, w.last);
            end
         end
      end
   end

   task automatic step(input bit v, input bit b, input bit d, input bit r);
      pk.bin_vld   = v;
      pk.bin_msg   = b;
      pk.msg_done  = d;
      pk.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit done_last, input bit r);
      for (int i = 0; i < 8; i++) step(1'b1, v[7-i], done_last && (i == 7), r);
   endtask

   task automatic idle(input int n, input bit r);
      repeat (n) step(1'b0, 1'b0, 1'b0, r);
   endtask

   initial begin
      pk.bin_vld   = 1'b0;
      pk.bin_msg   = 1'b0;
      pk.msg_done  = 1'b0;
      pk.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full word then empty terminating word.
      send_byte(8'hB2, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(4, 1'b1);

      // Partial word ended together with its last bit.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      idle(4, 1'b1);

      // Full word ended on its 8th bit: no extra empty word.
      send_byte(8'hA5, 1'b1, 1'b1);
      idle(4, 1'b1);

      // Queue full, third push coincides with a pop: nothing dropped.
      send_byte(8'h11, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, i[0], 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      idle(5, 1'b1);
      chk("no_ovf_on_pop_push", pk.ovf, 0);

      // Stalled consumer: third word dropped, ovf sticks, two words drain.
      send_byte(8'h3C, 1'b0, 1'b0);
      send_byte(8'h5A, 1'b0, 1'b0);
      send_byte(8'h96, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk("ovf_set", pk.ovf, 1);
      idle(5, 1'b1);
      chk("drained_valid", pk.out_valid, 0);
      chk("ovf_sticky", pk.ovf, 1);

      // Reset mid-message.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk("amid_valid", pk.out_valid, 0);
      chk("amid_busy",  pk.busy, 0);
      chk("amid_ovf",   pk.ovf, 0);
      chk("amid_data",  pk.out_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      send_byte(8'hFF, 1'b0, 1'b1);
      idle(4, 1'b1);

      // Random traffic.
      repeat (3000)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
      idle(6, 1'b1);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
